// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: walks each instruction FETCH..WRITEBACK over one shared ALU/memory port.
// Datapath controls are registered from the next state; ir_write/pc_write add the Mealy handshake terms.
module multicycle_ctrl #(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] ext_op,
   output logic [3:0] state,
   output logic       illegal
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_OR     = 3'b010;
   localparam logic [2:0] ALU_PASS_B = 3'b011;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HI   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_TRAP   = 4'd11
   } state_t;

   // pc_jump is the registered (JUMP-state) part of pc_write.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pc_jump;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] ext_op;
   } ctrl_t;

   localparam ctrl_t CTRL_FETCH = '{mem_req: 1'b1, alu_src_b: 2'd1, default: '0};

   state_t cur;
   state_t nxt;
   ctrl_t  ctrl_q;
   ctrl_t  ctrl_nxt;
   logic   illegal_q;

   always_comb begin
      nxt = cur;
      case (cur)
         S_FETCH:  if (mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     FN_ADDU, FN_SUBU: nxt = S_EXEC_R;
                     FN_JR:            nxt = S_JUMP;
                     FN_NOP:           nxt = S_FETCH;
                     default:          ;
                  endcase
               end
               OP_ORI, OP_LUI: nxt = S_EXEC_I;
               OP_LW, OP_SW:   nxt = S_ADDR;
               OP_BEQ:         nxt = S_BRANCH;
               OP_J, OP_JAL:   nxt = S_JUMP;
               default:        ;
            endcase
         end
         S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
         S_ADDR:   nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ready) nxt = S_WB_MEM;
         S_MEM_WR: if (mem_ready) nxt = S_FETCH;
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: nxt = S_FETCH;
         S_TRAP:   nxt = S_TRAP;
         default:  nxt = S_FETCH;
      endcase
   end

   // Decode the state being entered so the registered controls are valid throughout it.
   // IR is loaded on FETCH exit, and DECODE's controls are opcode-independent.
   always_comb begin
      ctrl_nxt = '0;
      case (nxt)
         S_FETCH:  ctrl_nxt = CTRL_FETCH;
         S_DECODE: begin
            ctrl_nxt.alu_src_b = 2'd3;
            ctrl_nxt.ext_op    = EXT_SIGN;
            ctrl_nxt.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            ctrl_nxt.alu_src_a = 1'b1;
            ctrl_nxt.alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
         end
         S_EXEC_I: begin
            ctrl_nxt.alu_src_b = 2'd2;
            ctrl_nxt.ext_op    = (opcode == OP_LUI) ? EXT_HI : EXT_ZERO;
            ctrl_nxt.alu_op    = (opcode == OP_LUI) ? ALU_PASS_B : ALU_OR;
         end
         S_WB_ALU: begin
            ctrl_nxt.reg_write = 1'b1;
            ctrl_nxt.reg_dst   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
         end
         S_ADDR: begin
            ctrl_nxt.alu_src_a = 1'b1;
            ctrl_nxt.alu_src_b = 2'd2;
            ctrl_nxt.ext_op    = EXT_SIGN;
         end
         S_MEM_RD: begin
            ctrl_nxt.mem_req = 1'b1;
            ctrl_nxt.iord    = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_nxt.mem_req = 1'b1;
            ctrl_nxt.mem_we  = 1'b1;
            ctrl_nxt.iord    = 1'b1;
         end
         S_WB_MEM: begin
            ctrl_nxt.reg_write  = 1'b1;
            ctrl_nxt.mem_to_reg = 2'd1;
         end
         S_BRANCH: begin
            ctrl_nxt.alu_src_a = 1'b1;
            ctrl_nxt.alu_op    = ALU_SUB;
            ctrl_nxt.pc_src    = 2'd1;
         end
         S_JUMP: begin
            ctrl_nxt.pc_jump = 1'b1;
            ctrl_nxt.pc_src  = (opcode == OP_RTYPE) ? 2'd3 : 2'd2;
            if (opcode == OP_JAL) begin
               ctrl_nxt.reg_write  = 1'b1;
               ctrl_nxt.reg_dst    = 2'd2;
               ctrl_nxt.mem_to_reg = 2'd2;
            end
         end
         default: ctrl_nxt = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur       <= S_FETCH;
         ctrl_q    <= CTRL_FETCH;
         illegal_q <= 1'b0;
      end else begin
         cur    <= nxt;
         ctrl_q <= ctrl_nxt;
         if (nxt == S_TRAP) illegal_q <= 1'b1;
      end
   end

   // Registers hold FETCH values during reset so FETCH is live on release; gating keeps outputs 0 meanwhile.
   assign mem_req    = ctrl_q.mem_req & ~reset;
   assign mem_we     = ctrl_q.mem_we & ~reset;
   assign iord       = ctrl_q.iord & ~reset;
   assign pc_src     = reset ? 2'd0 : ctrl_q.pc_src;
   assign reg_write  = ctrl_q.reg_write & ~reset;
   assign reg_dst    = reset ? 2'd0 : ctrl_q.reg_dst;
   assign mem_to_reg = reset ? 2'd0 : ctrl_q.mem_to_reg;
   assign alu_src_a  = ctrl_q.alu_src_a & ~reset;
   assign alu_src_b  = reset ? 2'd0 : ctrl_q.alu_src_b;
   assign alu_op     = reset ? 3'd0 : ctrl_q.alu_op;
   assign ext_op     = reset ? 2'd0 : ctrl_q.ext_op;
   assign illegal    = illegal_q & ~reset;
   assign state      = cur;

   assign ir_write = ~reset & (cur == S_FETCH) & mem_ready;
   assign pc_write = ~reset & (((cur == S_FETCH) & mem_ready) |
                               ((cur == S_BRANCH) & zero) |
                               ctrl_q.pc_jump);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class with hand-computed expectations.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] ext_op;
   logic [3:0] state;
   logic       illegal;

   multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .ext_op     (ext_op),
      .state      (state),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   logic [20:0] out_bus;
   logic [4:0]  en_bus;
   assign out_bus = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, illegal};
   assign en_bus  = {mem_req, mem_we, ir_write, pc_write, reg_write};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      mem_ready = 1'b1;
      zero = 1'b0;
      set_instr(6'h00, 6'h21);

      // reset: every output 0, even with mem_ready high
      #12;
      check("rst_outputs", 32'(out_bus), 0);
      check("rst_state", 32'(state), 0);
      reset = 1'b0;
      #1;
      check("fetch_state", 32'(state), 0);
      check("fetch_mem_req", 32'(mem_req), 1);
      check("fetch_ir_write", 32'(ir_write), 1);
      check("fetch_pc_write", 32'(pc_write), 1);
      check("fetch_alu_src_b", 32'(alu_src_b), 1);
      check("fetch_iord", 32'(iord), 0);

      // addu: 0,1,2,7,0
      tick();
      check("addu_s1", 32'(state), 1);
      check("decode_alu_src_b", 32'(alu_src_b), 3);
      check("decode_ext_op", 32'(ext_op), 1);
      check("decode_enables", 32'(en_bus), 0);
      tick();
      check("addu_s2", 32'(state), 2);
      check("addu_alu_src_a", 32'(alu_src_a), 1);
      check("addu_alu_src_b", 32'(alu_src_b), 0);
      check("addu_alu_op", 32'(alu_op), 0);
      check("addu_no_wr_exec", 32'(reg_write), 0);
      tick();
      check("addu_s7", 32'(state), 7);
      check("addu_reg_write", 32'(reg_write), 1);
      check("addu_reg_dst", 32'(reg_dst), 1);
      check("addu_mem_to_reg", 32'(mem_to_reg), 0);
      tick();
      check("addu_back_fetch", 32'(state), 0);
      check("addu_no_wr_fetch", 32'(reg_write), 0);

      // subu selects SUB in EXEC_R
      set_instr(6'h00, 6'h23);
      tick();
      tick();
      check("subu_s2", 32'(state), 2);
      check("subu_alu_op", 32'(alu_op), 1);
      tick();
      tick();
      check("subu_back_fetch", 32'(state), 0);

      // lw with three wait cycles in MEM_RD
      set_instr(6'h23, 6'h00);
      tick();
      tick();
      check("lw_addr_state", 32'(state), 4);
      check("lw_addr_src_a", 32'(alu_src_a), 1);
      check("lw_addr_src_b", 32'(alu_src_b), 2);
      check("lw_addr_ext", 32'(ext_op), 1);
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lw_wait%0d_state", i), 32'(state), 5);
         check($sformatf("lw_wait%0d_req_iord", i), 32'({mem_req, iord, mem_we}), 32'b110);
         tick();
      end
      check("lw_last_rd_state", 32'(state), 5);
      mem_ready = 1'b1;
      tick();
      check("lw_wb_state", 32'(state), 8);
      check("lw_wb_reg_write", 32'(reg_write), 1);
      check("lw_wb_reg_dst", 32'(reg_dst), 0);
      check("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
      tick();
      check("lw_back_fetch", 32'(state), 0);

      // FETCH waits while memory is not ready
      mem_ready = 1'b0;
      #1;
      check("fwait_ir_write", 32'(ir_write), 0);
      check("fwait_pc_write", 32'(pc_write), 0);
      check("fwait_mem_req", 32'(mem_req), 1);
      tick();
      check("fwait_state", 32'(state), 0);
      mem_ready = 1'b1;
      #1;
      check("fwait_done_ir_write", 32'(ir_write), 1);

      // beq: pc_write follows zero
      set_instr(6'h04, 6'h00);
      zero = 1'b1;
      tick();
      tick();
      check("beq_state", 32'(state), 9);
      check("beq_taken_pc_write", 32'(pc_write), 1);
      check("beq_pc_src", 32'(pc_src), 1);
      check("beq_alu_op", 32'(alu_op), 1);
      check("beq_alu_src", 32'({alu_src_a, alu_src_b}), 32'b100);
      zero = 1'b0;
      #1;
      check("beq_not_taken_pc_write", 32'(pc_write), 0);
      tick();
      check("beq_back_fetch", 32'(state), 0);

      // jal writes $31 with PC
      set_instr(6'h03, 6'h00);
      tick();
      tick();
      check("jal_state", 32'(state), 10);
      check("jal_pc_write", 32'(pc_write), 1);
      check("jal_pc_src", 32'(pc_src), 2);
      check("jal_reg_write", 32'(reg_write), 1);
      check("jal_reg_dst", 32'(reg_dst), 2);
      check("jal_mem_to_reg", 32'(mem_to_reg), 2);
      tick();
      check("jal_back_fetch", 32'(state), 0);

      // jr jumps to rs without a register write
      set_instr(6'h00, 6'h08);
      tick();
      tick();
      check("jr_state", 32'(state), 10);
      check("jr_pc_src", 32'(pc_src), 3);
      check("jr_pc_write", 32'(pc_write), 1);
      check("jr_reg_write", 32'(reg_write), 0);
      tick();

      // nop returns after two cycles
      set_instr(6'h00, 6'h00);
      tick();
      check("nop_decode", 32'(state), 1);
      tick();
      check("nop_back_fetch", 32'(state), 0);

      // lui: zero-filled upper immediate through PASS_B
      set_instr(6'h0F, 6'h00);
      tick();
      tick();
      check("lui_state", 32'(state), 3);
      check("lui_alu_src_b", 32'(alu_src_b), 2);
      check("lui_ext_op", 32'(ext_op), 2);
      check("lui_alu_op", 32'(alu_op), 3);
      tick();
      check("lui_wb_dst", 32'({reg_write, reg_dst}), 32'b100);
      tick();

      // ori: zero-extended OR
      set_instr(6'h0D, 6'h00);
      tick();
      tick();
      check("ori_ext_alu", 32'({ext_op, alu_op}), 32'b00010);
      tick();
      tick();

      // sw stalled in MEM_WR, then reset aborts the store
      set_instr(6'h2B, 6'h00);
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      check("sw_state", 32'(state), 6);
      check("sw_req_we_iord", 32'({mem_req, mem_we, iord, reg_write}), 32'b1110);
      #2;
      reset = 1'b1;
      #1;
      check("sw_rst_mem_we", 32'(mem_we), 0);
      check("sw_rst_mem_req", 32'(mem_req), 0);
      check("sw_rst_state", 32'(state), 0);
      #2;
      reset = 1'b0;
      #1;
      check("sw_rel_fetch", 32'({mem_req, mem_we, iord, ir_write}), 32'b1000);
      tick();
      check("sw_no_retry", 32'(state), 0);
      mem_ready = 1'b1;

      // undefined opcode traps and stays
      set_instr(6'h3F, 6'h00);
      tick();
      tick();
      check("trap_state", 32'(state), 11);
      check("trap_illegal", 32'(illegal), 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("trap_hold%0d", i), 32'({state, illegal, en_bus}), 32'({4'd11, 1'b1, 5'b0}));
      end
      #2;
      reset = 1'b1;
      #1;
      check("trap_rst_illegal", 32'(illegal), 0);
      check("trap_rst_state", 32'(state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
